// File: rtl/mosby_pkg.sv
// Shared constants and fetch FSM state encoding for the instruction-fetch front end.
package mosby_pkg;

    localparam logic [7:0]  NOP_OPCODE   = 8'hEA;
    localparam logic [15:0] RESET_VECTOR = 16'hFFFC;

    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        RUN    = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue_byte_fifo.sv
// Small power-of-two byte FIFO with synchronous clear, used as the prefetch buffer.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_2,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wr_data,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_2) begin
        if (!rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_2) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Prefetch stage: fetches the reset vector, then streams program bytes into a FIFO for the decoder.
module fetch_queue
    import mosby_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter logic [15:0] VECTOR_ADDR = RESET_VECTOR,
    parameter logic [7:0]  NOP_OP      = NOP_OPCODE
) (
    input  logic        clk_2,
    input  logic        rst,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ready,
    input  logic [7:0]  mem_data,
    input  logic        consume,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [7:0]  instruction,
    output logic [15:0] head_pc,
    output logic        flush,
    output logic        normal
);

    fetch_state_t            state;
    logic [15:0]             fetch_pc;
    logic [7:0]              vec_lo;
    logic [$clog2(DEPTH):0]  count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [7:0]              fifo_data;
    logic                    push;
    logic                    pop;
    logic                    clear;

    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = fetch_pc;
        case (state)
            VEC_LO: begin
                mem_rd   = 1'b1;
                mem_addr = VECTOR_ADDR;
            end
            VEC_HI: begin
                mem_rd   = 1'b1;
                mem_addr = VECTOR_ADDR + 16'd1;
            end
            RUN:     mem_rd = !fifo_full;
            default: mem_rd = 1'b0;
        endcase
    end

    // A redirect wins over both push and pop, so the returning read is dropped.
    assign clear = (state == RUN) && redirect;
    assign push  = (state == RUN) && mem_rd && mem_ready && !redirect;
    assign pop   = (state == RUN) && consume && !fifo_empty && !redirect;

    assign instruction = fifo_empty ? NOP_OP : fifo_data;
    assign normal      = (state == RUN) && (count != '0) && !flush;

    byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_2  (clk_2),
        .rst    (rst),
        .clear  (clear),
        .push   (push),
        .pop    (pop),
        .wr_data(mem_data),
        .rd_data(fifo_data),
        .count  (count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // flush stays high through the vector fetch and for one cycle after each redirect.
    always_ff @(posedge clk_2) begin
        if (!rst) begin
            state    <= VEC_LO;
            fetch_pc <= VECTOR_ADDR;
            head_pc  <= '0;
            vec_lo   <= '0;
            flush    <= 1'b1;
        end else begin
            case (state)
                VEC_LO: begin
                    if (mem_ready) begin
                        vec_lo <= mem_data;
                        state  <= VEC_HI;
                    end
                end
                VEC_HI: begin
                    if (mem_ready) begin
                        fetch_pc <= {mem_data, vec_lo};
                        head_pc  <= {mem_data, vec_lo};
                        flush    <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    flush <= redirect;
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        head_pc  <= redirect_pc;
                    end else begin
                        if (push) fetch_pc <= fetch_pc + 16'd1;
                        if (pop)  head_pc  <= head_pc + 16'd1;
                    end
                end
                default: state <= VEC_LO;
            endcase
        end
    end

endmodule
